cntr_param: RTL
===============

// Module: cntr_param
// PURPOSE
//  Parametrised loadable up/down counter; next generation of the 8-bit cntr8.
//  Adds configurable width and modulus, a wrap/saturate mode and a count enable.
//  Adds a one-cycle terminal-count flag.
//  The 3-bit FSM state encoding used for counter observation is kept unchanged.
//  Serves as the counting element for timers, address generators and BCD/mod-N stages.
// PARAMETERS
//  WIDTH    8             counter width in bits (2..32)
//  MAX_VAL  2**WIDTH-1    highest count value (modulus-1); 1 <= MAX_VAL <= 2**WIDTH-1
//  SAT_MODE 0             0 = wrap at boundaries, 1 = saturate at 0 / MAX_VAL
// PORTS
//  clk     in   1      rising-edge clock
//  reset   in   1      asynchronous, active-high reset
//  en      in   1      count enable
//  load    in   1      synchronous load of d_in; priority over en
//  inc     in   1      direction: 1 = up, 0 = down
//  d_in    in   WIDTH  load value
//  d_out   out  WIDTH  registered count
//  state   out  3      registered FSM state
//  tc      out  1      registered terminal-count pulse
// BEHAVIOUR
//  - Reset (async, any time, incl. mid-count): d_out=0, state=IDLE, tc=0.
//  - Release of reset takes effect at the next rising clk edge.
//  - States: IDLE=3'b000, LOAD=3'b001, INC=3'b010, INC2=3'b011, DEC=3'b100, DEC2=3'b101.
//  - Encodings 110 and 111 are unreachable; if entered, the FSM goes to IDLE with d_out held.
//  - Next-state priority, evaluated every edge:
//    load=1 -> LOAD; else en=0 -> IDLE; else inc=1 -> INC/INC2; else DEC/DEC2.
//  - INC alternates with INC2 on consecutive up-counts: INC->INC2->INC...
//  - Any other state entering the up-count goes to INC. DEC/DEC2 follow the same rule.
//  - Outputs are registered and updated on the same edge as the state.
//  - Latency is 1 clk from input sample to d_out.
//  - LOAD: d_out <= d_in; if d_in > MAX_VAL, d_out <= MAX_VAL and tc <= 1.
//  - IDLE: d_out is held.
//  - Up-count at d_out==MAX_VAL: SAT_MODE=0 -> d_out <= 0; SAT_MODE=1 -> d_out is held.
//    tc <= 1 in both cases.
//  - Up-count below MAX_VAL: d_out <= d_out+1, tc <= 0.
//  - Down-count at d_out==0: SAT_MODE=0 -> d_out <= MAX_VAL; SAT_MODE=1 -> d_out is held.
//    tc <= 1 in both cases.
//  - Down-count above 0: d_out <= d_out-1, tc <= 0.
//  - tc is high for exactly one cycle per boundary event.
//  - Repeated saturation attempts re-assert tc every cycle.
//  - load and en both high: load wins, no count occurs.
//  - A direction change mid-count takes effect on the next edge, with no dead cycle.
//  - All arithmetic is unsigned, WIDTH bits. No intermediate value may exceed WIDTH bits.
// TESTING
//  1. WIDTH=8 default: reset high, then low, en=1, inc=1 for 3 clks
//     -> d_out 1,2,3; state 010,011,010; tc=0.
//  2. MAX_VAL=9, SAT_MODE=0: load 8, then count up 3 clks
//     -> d_out 9,0,1; tc=1 only on the 9->0 cycle. Count down from 0 -> 9 with tc=1.
//  3. MAX_VAL=9, SAT_MODE=1: load 8, then count up 3 clks
//     -> d_out 9,9,9; tc=0,1,1. From 0, count down -> d_out stays 0, tc=1.
//  4. load=1, en=1, d_in=8'h0C -> d_out=0x0C, state=001.
//     With MAX_VAL=9 and d_in=8'hCA -> d_out=9, tc=1.
//  5. Counting at 0x55: assert reset between clk edges
//     -> d_out=0, state=000 immediately, without waiting for clk. Counting resumes after release.
//  6. en=0 with inc toggling -> d_out held, state=000, tc=0.
//     inc 1->0 while en=1 -> next state DEC, d_out decrements on that edge.

Source files
------------

// File: rtl/cntr_param_if.sv
// Control and observation bundle for cntr_param: the master drives load/count
// controls, the slave (counter) returns the registered count, FSM state and tc.
interface cntr_param_if #(
    parameter int WIDTH = 8
);
    logic             en;
    logic             load;
    logic             inc;
    logic [WIDTH-1:0] d_in;
    logic [WIDTH-1:0] d_out;
    logic [2:0]       state;
    logic             tc;

    modport master (
        output en, load, inc, d_in,
        input  d_out, state, tc
    );

    modport slave (
        input  en, load, inc, d_in,
        output d_out, state, tc
    );
endinterface

// File: rtl/cntr_param.sv
// Parametrised loadable up/down counter with wrap/saturate mode and a
// registered one-cycle terminal-count flag; FSM state is exported for observation.
//
// state  | meaning
// -------+----------------------------------------------
// IDLE   | not counting, count held
// LOAD   | count loaded from d_in (clamped to MAX_VAL)
// INC    | odd up-count in a run of consecutive up-counts
// INC2   | even up-count in a run of consecutive up-counts
// DEC    | odd down-count in a run of consecutive down-counts
// DEC2   | even down-count in a run of consecutive down-counts
module cntr_param #(
    parameter int             WIDTH    = 8,
    parameter logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}},
    parameter bit             SAT_MODE = 1'b0
) (
    input  logic         clk,
    input  logic         reset,
    cntr_param_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE = 3'b000,
        S_LOAD = 3'b001,
        S_INC  = 3'b010,
        S_INC2 = 3'b011,
        S_DEC  = 3'b100,
        S_DEC2 = 3'b101
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_cnt;
    logic             r_tc;

    state_t           w_state_nxt;
    logic [WIDTH-1:0] w_cnt_nxt;
    logic             w_tc_nxt;
    logic             w_illegal;

    assign w_illegal = r_state[2] & r_state[1];

    always_comb begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = r_cnt;
        w_tc_nxt    = 1'b0;
        // Encodings 110/111 recover to IDLE regardless of inputs, count held.
        if (w_illegal) begin
            w_state_nxt = S_IDLE;
        end else if (bus.load) begin
            w_state_nxt = S_LOAD;
            if (bus.d_in > MAX_VAL) begin
                w_cnt_nxt = MAX_VAL;
                w_tc_nxt  = 1'b1;
            end else begin
                w_cnt_nxt = bus.d_in;
            end
        end else if (!bus.en) begin
            w_state_nxt = S_IDLE;
        end else if (bus.inc) begin
            w_state_nxt = (r_state == S_INC) ? S_INC2 : S_INC;
            if (r_cnt == MAX_VAL) begin
                w_tc_nxt  = 1'b1;
                w_cnt_nxt = SAT_MODE ? r_cnt : '0;
            end else begin
                w_cnt_nxt = r_cnt + 1'b1;
            end
        end else begin
            w_state_nxt = (r_state == S_DEC) ? S_DEC2 : S_DEC;
            if (r_cnt == '0) begin
                w_tc_nxt  = 1'b1;
                w_cnt_nxt = SAT_MODE ? r_cnt : MAX_VAL;
            end else begin
                w_cnt_nxt = r_cnt - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_tc    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_tc    <= w_tc_nxt;
        end
    end

    assign bus.d_out = r_cnt;
    assign bus.state = r_state;
    assign bus.tc    = r_tc;

endmodule
